dac_frame_scheduler: RTL and testbench

Sample-rate scheduler between the two per-channel waveform sources and the dual-DAC SPI serializer. On every programmable sample tick it pulls one 12-bit DAC word from each channel source with a valid/ready handshake. It then latches both words and launches one serializer transfer. It also reports underrun (source had no word), overrun (tick arrived while a transfer was in flight) and serializer timeout.

---
 rtl/dac_sched_pkg.sv | 20 ++
 rtl/rate_divider.sv | 37 +++
 rtl/dac_frame_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_dac_frame_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_sched_pkg.sv
// -----------------------------------------------------------------------------
// dac_sched_pkg
// Shared types and constants for the DAC frame scheduler:
//   - sched_state_t : scheduler FSM states
//   - DAC_WORD_W    : width of one DAC sample word
//   - DAC_MIDSCALE  : mid-scale code, used as the idle/reset DAC output
// -----------------------------------------------------------------------------
package dac_sched_pkg;

  localparam int DAC_WORD_W   = 12;
  localparam int DAC_MIDSCALE = 2048;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    LAUNCH    = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rate_divider.sv
// -----------------------------------------------------------------------------
// rate_divider
// Programmable sample-period down-counter.
//   CLK100   in  system clock
//   RESET_N  in  asynchronous active-low reset (counter -> 0)
//   ENABLE   in  run the divider; when low the counter holds at RATE_DIV
//   RATE_DIV in  sample period in clocks minus 1, reloaded at every tick
//   TICK     out combinational one-cycle pulse when the count reaches 0
// -----------------------------------------------------------------------------
module rate_divider #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 CLK100,
  input  logic                 RESET_N,
  input  logic                 ENABLE,
  input  logic [DIV_WIDTH-1:0] RATE_DIV,
  output logic                 TICK
);

  logic [DIV_WIDTH-1:0] count_reg;

  // Tick is combinational so the scheduler can raise READY in the same cycle.
  assign TICK = ENABLE && (count_reg == '0);

  always_ff @(posedge CLK100 or negedge RESET_N) begin
    if (!RESET_N) begin
      count_reg <= '0;
    end else if (!ENABLE || TICK) begin
      // While disabled the counter is preloaded, so the first tick after
      // enabling arrives RATE_DIV clocks later.
      count_reg <= RATE_DIV;
    end else begin
      count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/dac_frame_scheduler.sv
// -----------------------------------------------------------------------------
// dac_frame_scheduler
// Pulls one word from each channel source on every sample tick, latches the
// pair for the dual-DAC serializer and launches one transfer. Reports sticky
// underrun / overrun / serializer-timeout flags.
//   CLK100, RESET_N        clock, asynchronous active-low reset
//   ENABLE                 run divider and scheduler
//   RATE_DIV               sample period in clocks minus 1
//   CLEAR_FLAGS            pulse, clears sticky flags (a same-cycle set wins)
//   A_VALID/A_WORD/A_READY channel A source handshake (B likewise)
//   DAC_A, DAC_B           latched words to the serializer (registered)
//   DAC_START              one-cycle launch pulse (registered)
//   DAC_DONE               end-of-transfer pulse from the serializer
//   SAMPLE_TICK            combinational tick pulse
//   UNDERRUN[1:0]          sticky, bit0 = A, bit1 = B
//   OVERRUN                sticky, tick arrived while not waiting for one
//   FAULT                  sticky, serializer did not answer in time
// -----------------------------------------------------------------------------
module dac_frame_scheduler
  import dac_sched_pkg::*;
#(
  parameter int DIV_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int IDLE_WORD      = DAC_MIDSCALE
) (
  input  logic                  CLK100,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic [DIV_WIDTH-1:0]  RATE_DIV,
  input  logic                  CLEAR_FLAGS,
  input  logic                  A_VALID,
  input  logic                  B_VALID,
  input  logic [DAC_WORD_W-1:0] A_WORD,
  input  logic [DAC_WORD_W-1:0] B_WORD,
  output logic                  A_READY,
  output logic                  B_READY,
  output logic [DAC_WORD_W-1:0] DAC_A,
  output logic [DAC_WORD_W-1:0] DAC_B,
  output logic                  DAC_START,
  input  logic                  DAC_DONE,
  output logic                  SAMPLE_TICK,
  output logic [1:0]            UNDERRUN,
  output logic                  OVERRUN,
  output logic                  FAULT
);

  // Timeout counter counts WAIT_DONE cycles 0 .. TIMEOUT_CYCLES-1.
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DAC_WORD_W-1:0] IDLE_VAL = DAC_WORD_W'(IDLE_WORD);

  sched_state_t    state_reg, state_next;
  logic            tick;
  logic            accept;
  logic            overrun_set;
  logic            fault_set;
  logic            timeout_hit;
  logic [TO_W-1:0] to_cnt_reg;
  logic            dac_start_reg;
  logic            overrun_reg;
  logic            fault_reg;

  logic [1:0]            ch_valid;
  logic [1:0]            ch_ready;
  logic [DAC_WORD_W-1:0] ch_word [2];

  rate_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_rate_divider (
    .CLK100   (CLK100),
    .RESET_N  (RESET_N),
    .ENABLE   (ENABLE),
    .RATE_DIV (RATE_DIV),
    .TICK     (tick)
  );

  // A tick is only consumed while the scheduler is waiting for one; any other
  // state (including IDLE and the DAC_DONE cycle itself) drops the sample.
  assign accept      = tick && (state_reg == WAIT_TICK);
  assign overrun_set = tick && (state_reg != WAIT_TICK);
  assign timeout_hit = (state_reg == WAIT_DONE) && (to_cnt_reg == TO_LAST);

  assign ch_valid   = {B_VALID, A_VALID};
  assign ch_word[0] = A_WORD;
  assign ch_word[1] = B_WORD;

  // Per-channel word latch and underrun flag.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [DAC_WORD_W-1:0] dac_reg;
    logic                  underrun_reg;

    assign ch_ready[gi] = accept && ch_valid[gi];

    always_ff @(posedge CLK100 or negedge RESET_N) begin
      if (!RESET_N) begin
        dac_reg      <= IDLE_VAL;
        underrun_reg <= 1'b0;
      end else begin
        // A missing word keeps the previous sample on the DAC.
        if (ch_ready[gi]) begin
          dac_reg <= ch_word[gi];
        end
        if (accept && !ch_valid[gi]) begin
          underrun_reg <= 1'b1;
        end else if (CLEAR_FLAGS) begin
          underrun_reg <= 1'b0;
        end
      end
    end
  end

  assign A_READY     = ch_ready[0];
  assign B_READY     = ch_ready[1];
  assign DAC_A       = g_ch[0].dac_reg;
  assign DAC_B       = g_ch[1].dac_reg;
  assign UNDERRUN    = {g_ch[1].underrun_reg, g_ch[0].underrun_reg};
  assign SAMPLE_TICK = tick;
  assign DAC_START   = dac_start_reg;
  assign OVERRUN     = overrun_reg;
  assign FAULT       = fault_reg;

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    fault_set  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ENABLE) state_next = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!ENABLE)    state_next = IDLE;
        else if (tick)  state_next = LAUNCH;
      end
      LAUNCH: begin
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A DONE that lands on the last allowed cycle still counts as on time.
        if (!ENABLE) begin
          state_next = IDLE;
        end else if (DAC_DONE) begin
          state_next = WAIT_TICK;
        end else if (timeout_hit) begin
          state_next = WAIT_TICK;
          fault_set  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      to_cnt_reg    <= '0;
      dac_start_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      // The start pulse coincides with the single LAUNCH cycle.
      dac_start_reg <= accept;

      if (state_reg == LAUNCH) begin
        to_cnt_reg <= '0;
      end else if (state_reg == WAIT_DONE) begin
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end

      if (overrun_set)      overrun_reg <= 1'b1;
      else if (CLEAR_FLAGS) overrun_reg <= 1'b0;

      if (fault_set)        fault_reg <= 1'b1;
      else if (CLEAR_FLAGS) fault_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dac_frame_scheduler
// Randomized bench for dac_frame_scheduler. A reference model predicts tick
// times from the programmed period, decides per tick whether the scheduler is
// free (from the serializer latency it chose), and pushes every expected
// launch into a queue. A separate monitor pops that queue whenever DAC_START
// is seen and compares the launch cycle and words.
// -----------------------------------------------------------------------------
module tb_dac_frame_scheduler;

  localparam int TO = 50;

  logic        CLK100 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic [15:0] RATE_DIV = '0;
  logic        CLEAR_FLAGS = 1'b0;
  logic        A_VALID = 1'b0;
  logic        B_VALID = 1'b0;
  logic [11:0] A_WORD = '0;
  logic [11:0] B_WORD = '0;
  logic        A_READY, B_READY;
  logic [11:0] DAC_A, DAC_B;
  logic        DAC_START;
  logic        DAC_DONE = 1'b0;
  logic        SAMPLE_TICK;
  logic [1:0]  UNDERRUN;
  logic        OVERRUN;
  logic        FAULT;

  dac_frame_scheduler #(
    .DIV_WIDTH      (16),
    .TIMEOUT_CYCLES (TO),
    .IDLE_WORD      (2048)
  ) dut (
    .CLK100      (CLK100),
    .RESET_N     (RESET_N),
    .ENABLE      (ENABLE),
    .RATE_DIV    (RATE_DIV),
    .CLEAR_FLAGS (CLEAR_FLAGS),
    .A_VALID     (A_VALID),
    .B_VALID     (B_VALID),
    .A_WORD      (A_WORD),
    .B_WORD      (B_WORD),
    .A_READY     (A_READY),
    .B_READY     (B_READY),
    .DAC_A       (DAC_A),
    .DAC_B       (DAC_B),
    .DAC_START   (DAC_START),
    .DAC_DONE    (DAC_DONE),
    .SAMPLE_TICK (SAMPLE_TICK),
    .UNDERRUN    (UNDERRUN),
    .OVERRUN     (OVERRUN),
    .FAULT       (FAULT)
  );

  always #5 CLK100 = ~CLK100;

  int cyc = 0;
  always @(posedge CLK100) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int cyc;
    int a;
    int b;
  } launch_t;

  launch_t q[$];
  launch_t mon_e;

  // Phase configuration.
  bit        cfg_en;
  int        cfg_rd;
  int        cfg_va_pct, cfg_vb_pct;
  bit        cfg_rand_words;
  logic [11:0] cfg_wa, cfg_wb;
  int        cfg_lat;
  bit        cfg_lat_rand;
  int        cfg_clr_pct;
  bit        cfg_collide;

  // Reference model state.
  bit        en_prev;
  int        next_tick, free_at, done_cyc, fault_cyc, last_start;
  bit        clr_follow;
  logic [11:0] exp_a, exp_b;
  logic [1:0]  exp_ur;
  logic        exp_or, exp_flt;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_a = 12'd2048; exp_b = 12'd2048;
    exp_ur = 2'b00; exp_or = 1'b0; exp_flt = 1'b0;
    en_prev = 1'b0; fault_cyc = -1; clr_follow = 1'b0;
    q.delete();
  endtask

  // One clock of stimulus plus model prediction.
  task automatic do_cycle();
    int n, lat, s;
    bit tick, acc, va, vb, clr, done, set_or, set_flt;
    bit [1:0] set_ur;
    logic [11:0] wa, wb, na, nb;
    launch_t le;

    @(negedge CLK100);
    n = cyc;
    chk("dac_a", DAC_A, exp_a);
    chk("dac_b", DAC_B, exp_b);
    chk("underrun", UNDERRUN, exp_ur);
    chk("overrun", OVERRUN, exp_or);
    chk("fault", FAULT, exp_flt);

    // Ticks fall RATE_DIV clocks after enabling, then every RATE_DIV+1.
    tick = 1'b0;
    if (cfg_en) begin
      if (!en_prev) begin
        next_tick = n + cfg_rd;
        free_at   = n + 1;
      end
      tick = (n == next_tick);
    end

    va = ($urandom_range(99) < cfg_va_pct);
    vb = ($urandom_range(99) < cfg_vb_pct);
    wa = cfg_rand_words ? 12'($urandom) : cfg_wa;
    wb = cfg_rand_words ? 12'($urandom) : cfg_wb;
    clr = clr_follow || ($urandom_range(99) < cfg_clr_pct);
    clr_follow = 1'b0;
    if (cfg_collide && tick && n < free_at) begin
      clr = 1'b1;
      clr_follow = 1'b1;
      cfg_collide = 1'b0;
    end
    done = (n == done_cyc);

    ENABLE = cfg_en; RATE_DIV = 16'(cfg_rd);
    A_VALID = va; B_VALID = vb; A_WORD = wa; B_WORD = wb;
    CLEAR_FLAGS = clr; DAC_DONE = done;
    #1;

    acc = tick && (n >= free_at);
    chk("sample_tick", SAMPLE_TICK, tick);
    chk("a_ready", A_READY, acc && va);
    chk("b_ready", B_READY, acc && vb);

    set_or  = tick && !acc;
    set_flt = cfg_en && (n == fault_cyc);
    if (!cfg_en) fault_cyc = -1;
    na = exp_a; nb = exp_b; set_ur = 2'b00;
    if (tick) next_tick = n + cfg_rd + 1;
    if (acc) begin
      if (va) na = wa;
      if (vb) nb = wb;
      set_ur = {!vb, !va};
      s = n + 1;
      le.cyc = s; le.a = na; le.b = nb;
      q.push_back(le);
      lat = cfg_lat_rand ? $urandom_range(60, 1) : cfg_lat;
      if (lat <= TO) begin
        done_cyc = s + lat; fault_cyc = -1; free_at = s + lat + 1;
      end else begin
        done_cyc = -1; fault_cyc = s + TO; free_at = s + TO + 1;
      end
      last_start = s;
    end

    exp_or  = set_or  ? 1'b1 : (clr ? 1'b0 : exp_or);
    exp_flt = set_flt ? 1'b1 : (clr ? 1'b0 : exp_flt);
    for (int i = 0; i < 2; i++)
      exp_ur[i] = set_ur[i] ? 1'b1 : (clr ? 1'b0 : exp_ur[i]);
    exp_a = na; exp_b = nb;
    en_prev = cfg_en;
  endtask

  // Launch monitor: every DAC_START must match the oldest expected launch.
  always @(negedge CLK100) begin
    if (RESET_N) begin
      if (DAC_START === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("start_cycle", cyc, mon_e.cyc);
          chk("launch_dac_a", DAC_A, mon_e.a);
          chk("launch_dac_b", DAC_B, mon_e.b);
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        mon_e = q.pop_front();
        chk("missing_start", 0, 1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    model_reset();
    next_tick = 0; free_at = 0; done_cyc = -1; last_start = -100;
    cfg_en = 0; cfg_rd = 999; cfg_va_pct = 100; cfg_vb_pct = 100;
    cfg_rand_words = 0; cfg_wa = 12'd157; cfg_wb = 12'd2073;
    cfg_lat = 300; cfg_lat_rand = 0; cfg_clr_pct = 0; cfg_collide = 0;

    // Reset values.
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK100);
    chk("rst_dac_a", DAC_A, 2048);
    chk("rst_dac_b", DAC_B, 2048);
    chk("rst_dac_start", DAC_START, 0);
    chk("rst_a_ready", A_READY, 0);
    chk("rst_b_ready", B_READY, 0);
    chk("rst_sample_tick", SAMPLE_TICK, 0);
    chk("rst_underrun", UNDERRUN, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_fault", FAULT, 0);
    RATE_DIV = 16'd999;
    RESET_N = 1'b1;

    // Nominal rate: period 1000, both sources valid, serializer 300 clocks.
    cfg_en = 1;
    repeat (3500) do_cycle();

    // Underrun: A first delivers 500, then goes empty while B keeps flowing.
    cfg_rd = 49; cfg_lat = 10; cfg_wa = 12'd500; cfg_wb = 12'd100;
    repeat (600) do_cycle();
    cfg_va_pct = 0; cfg_wb = 12'd3001;
    repeat (120) do_cycle();

    // Overrun: period 100 against a 200-clock serializer, with a clear
    // pulse landing on the first dropped tick and another right after.
    cfg_va_pct = 100; cfg_rand_words = 1; cfg_rd = 99; cfg_lat = 200;
    cfg_collide = 1;
    repeat (1500) do_cycle();

    // Timeout: serializer never answers.
    cfg_rd = 79; cfg_lat = 1000;
    repeat (400) do_cycle();

    // Random periods, latencies (some past the timeout), sources and clears.
    cfg_lat_rand = 1; cfg_va_pct = 75; cfg_vb_pct = 75; cfg_clr_pct = 3;
    for (int seg = 0; seg < 6; seg++) begin
      cfg_rd = $urandom_range(60, 3);
      repeat (250) do_cycle();
    end

    // Disable: no ticks, then resume.
    cfg_en = 0; cfg_rd = 7;
    repeat (300) do_cycle();
    cfg_en = 1;
    repeat (300) do_cycle();

    // Reset while the serializer transfer is in flight.
    cfg_rd = 99; cfg_lat_rand = 0; cfg_lat = 40; cfg_va_pct = 50; cfg_clr_pct = 0;
    for (int k = 0; k < 3000; k++) begin
      do_cycle();
      if (cyc > last_start + 2 && done_cyc > cyc + 10 && exp_a != 12'd2048) break;
    end
    chk("reset_window_found", int'(done_cyc > cyc + 10), 1);
    @(negedge CLK100);
    RESET_N = 1'b0; ENABLE = 1'b0; DAC_DONE = 1'b0; CLEAR_FLAGS = 1'b0;
    #1;
    chk("async_rst_dac_a", DAC_A, 2048);
    chk("async_rst_dac_b", DAC_B, 2048);
    chk("async_rst_underrun", UNDERRUN, 0);
    chk("async_rst_overrun", OVERRUN, 0);
    chk("async_rst_fault", FAULT, 0);
    chk("async_rst_dac_start", DAC_START, 0);
    model_reset();
    cfg_en = 0; cfg_rd = 20; RATE_DIV = 16'd20;
    repeat (2) @(negedge CLK100);
    RESET_N = 1'b1;
    // The orphaned DAC_DONE arrives in IDLE and must not launch anything.
    repeat (80) do_cycle();
    cfg_en = 1; cfg_va_pct = 90; cfg_lat_rand = 1;
    repeat (200) do_cycle();

    repeat (3) @(negedge CLK100);
    chk("pending_launches", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
